// File: rtl/dram_port_arbiter_pkg.sv
// rtl/dram_port_arbiter_pkg.sv - shared types and widths for the DRAM port arbiter
package dram_port_arbiter_pkg;

    localparam int ADDRESS_LEN        = 16;
    localparam int BURST_ACCESS_WIDTH = 32;
    localparam int DRAM_ARB_N_REQ     = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } dram_arb_state_t;

endpackage

// File: rtl/dram_port_arbiter_rr_arbiter.sv
// rtl/dram_port_arbiter_rr_arbiter.sv - combinational round-robin picker, scans from ptr+1 with wrap
module dram_port_arbiter_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin sharing of one DRAM port, one transaction in flight
// Optional watchdog timeout on WAIT: DRAM_ARB_WATCHDOG_EN
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int N_REQ       = DRAM_ARB_N_REQ,
    parameter int ADDR_W      = ADDRESS_LEN,
    parameter int DATA_W      = BURST_ACCESS_WIDTH,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic [ADDR_W-1:0]            addr,
    output logic                         read_en,
    output logic                         write_en,
    output logic [DATA_W-1:0]            wdata,
    input  logic                         dram_ready,
    input  logic                         dram_complete,
    input  logic [DATA_W-1:0]            rdata,
    input  logic                         valid
`ifdef DRAM_ARB_WATCHDOG_EN
    ,
    output logic                         wdog_err
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("dram_port_arbiter: N_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    dram_arb_state_t   state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  g_q, g_d;
    logic              we_q, we_d;
    logic [N_REQ-1:0]  win_grant;
    logic [PTR_W-1:0]  win_idx;
    logic [N_REQ-1:0]  g_onehot;

    logic [N_REQ-1:0]  req_ready_d, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              read_en_d, write_en_d;
    logic              done;

`ifdef DRAM_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_err_d;
`endif

    dram_port_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (win_grant),
        .idx   (win_idx)
    );

    assign g_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << g_q;
    assign done     = we_q ? dram_complete : valid;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        we_d         = we_q;
        addr_d       = addr;
        wdata_d      = wdata;
        read_en_d    = 1'b0;
        write_en_d   = 1'b0;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata;
`ifdef DRAM_ARB_WATCHDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
        wdog_err_d   = wdog_err;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid && dram_ready) begin
                    g_d         = win_idx;
                    ptr_d       = win_idx;
                    we_d        = req_we[win_idx];
                    addr_d      = req_addr[win_idx];
                    wdata_d     = req_wdata[win_idx];
                    read_en_d   = ~req_we[win_idx];
                    write_en_d  = req_we[win_idx];
                    req_ready_d = win_grant;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DRAM_ARB_WATCHDOG_EN
                wdog_cnt_d = '0;
`endif
            end
            WAIT: begin
                // Only the completion kind matching the latched direction counts
                if (done) begin
                    resp_valid_d = g_onehot;
                    if (!we_q) begin
                        resp_rdata_d = rdata;
                    end
                    state_d = IDLE;
                end
`ifdef DRAM_ARB_WATCHDOG_EN
                else if (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
                    resp_valid_d = g_onehot;
                    resp_rdata_d = '0;
                    wdog_err_d   = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(N_REQ - 1);
            g_q        <= '0;
            we_q       <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
`ifdef DRAM_ARB_WATCHDOG_EN
            wdog_cnt_q <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            we_q       <= we_d;
            addr       <= addr_d;
            wdata      <= wdata_d;
            read_en    <= read_en_d;
            write_en   <= write_en_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
`ifdef DRAM_ARB_WATCHDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err   <= wdog_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int WDOG   = 16;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [N_REQ-1:0]             req_valid = '0;
    logic [N_REQ-1:0]             req_we = '0;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr = '0;
    logic [N_REQ-1:0][DATA_W-1:0] req_wdata = '0;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]            resp_rdata;
    logic [ADDR_W-1:0]            addr;
    logic                         read_en;
    logic                         write_en;
    logic [DATA_W-1:0]            wdata;
    logic                         dram_ready = 1'b0;
    logic                         dram_complete = 1'b0;
    logic [DATA_W-1:0]            rdata = '0;
    logic                         valid = 1'b0;
`ifdef DRAM_ARB_WATCHDOG_EN
    logic                         wdog_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dram_port_arbiter #(
        .N_REQ       (N_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .addr          (addr),
        .read_en       (read_en),
        .write_en      (write_en),
        .wdata         (wdata),
        .dram_ready    (dram_ready),
        .dram_complete (dram_complete),
        .rdata         (rdata),
        .valid         (valid)
`ifdef DRAM_ARB_WATCHDOG_EN
        ,
        .wdog_err      (wdog_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        req_we = '0;
        dram_complete = 1'b0;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n;
        logic [N_REQ-1:0] exp_g;

        // Reset state
        do_reset();
        check("rst_read_en", read_en, 0);
        check("rst_write_en", write_en, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_wdata", wdata, 0);
`ifdef DRAM_ARB_WATCHDOG_EN
        check("rst_wdog_err", wdog_err, 0);
`endif

        // Single read from requester 0
        dram_ready = 1'b1;
        req_addr[0] = 16'h0040;
        req_valid = 2'b01;
        tick();
        check("rd_read_en", read_en, 1);
        check("rd_write_en", write_en, 0);
        check("rd_addr", addr, 16'h0040);
        check("rd_req_ready", req_ready, 2'b01);
        req_valid = '0;
        tick();
        check("rd_read_en_drop", read_en, 0);
        check("rd_req_ready_drop", req_ready, 0);
        valid = 1'b1;
        rdata = 32'hA5;
        tick();
        valid = 1'b0;
        check("rd_resp_valid", resp_valid, 2'b01);
        check("rd_resp_rdata", resp_rdata, 32'hA5);
        tick();
        check("rd_resp_valid_pulse", resp_valid, 0);

        // Continuous writes from both requesters, completion 3 cycles after issue
        do_reset();
        req_addr[0] = 16'h0100;
        req_addr[1] = 16'h0200;
        req_wdata[0] = 32'h1111_0000;
        req_wdata[1] = 32'h2222_0000;
        req_we = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            do begin
                tick();
                n++;
            end while (!write_en && n < 10);
            check("rr_issue_latency", n, 1);
            check("rr_req_ready", req_ready, exp_g);
            check("rr_addr", addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            check("rr_wdata", wdata, (k % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
            tick();
            tick();
            dram_complete = 1'b1;
            tick();
            dram_complete = 1'b0;
            check("rr_resp_valid", resp_valid, exp_g);
        end
        req_valid = '0;
        tick();

        // dram_ready held low blocks grants
        dram_ready = 1'b0;
        req_we = '0;
        req_addr[1] = 16'h0300;
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("nrdy_idle", {read_en, write_en, req_ready}, 0);
        end
        dram_ready = 1'b1;
        tick();
        check("nrdy_read_en", read_en, 1);
        check("nrdy_req_ready", req_ready, 2'b10);
        check("nrdy_addr", addr, 16'h0300);
        req_valid = '0;
        tick();
        valid = 1'b1;
        rdata = 32'h5A;
        tick();
        valid = 1'b0;
        check("nrdy_resp_valid", resp_valid, 2'b10);
        check("nrdy_resp_rdata", resp_rdata, 32'h5A);
        tick();

        // Requester 1 write with spurious read-valid during WAIT
        req_we = 2'b10;
        req_addr[1] = 16'h0310;
        req_wdata[1] = 32'hDEAD;
        req_valid = 2'b10;
        tick();
        check("spur_write_en", write_en, 1);
        check("spur_wdata", wdata, 32'hDEAD);
        req_valid = '0;
        tick();
        valid = 1'b1;
        rdata = 32'h1234;
        tick();
        valid = 1'b0;
        check("spur_ignored", resp_valid, 0);
        tick();
        check("spur_ignored2", resp_valid, 0);
        check("spur_addr_hold", addr, 16'h0310);
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        check("spur_resp_valid", resp_valid, 2'b10);
        check("spur_rdata_kept", resp_rdata, 32'h5A);
        tick();

        // Reset during a read WAIT abandons the transaction
        req_we = '0;
        req_valid = 2'b10;
        tick();
        check("mid_read_en", read_en, 1);
        req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
        check("mid_async_resp", resp_valid, 0);
        check("mid_async_addr", addr, 0);
        tick();
        rst = 1'b1;
        valid = 1'b1;
        rdata = 32'h77;
        tick();
        valid = 1'b0;
        check("mid_no_resp", resp_valid, 0);
        check("mid_rdata_zero", resp_rdata, 0);
        req_valid = 2'b11;
        tick();
        check("mid_first_grant", req_ready, 2'b01);
        req_valid = '0;
        tick();
        valid = 1'b1;
        rdata = 32'h99;
        tick();
        valid = 1'b0;
        check("mid_resp_valid", resp_valid, 2'b01);
        check("mid_resp_rdata", resp_rdata, 32'h99);
        tick();

`ifdef DRAM_ARB_WATCHDOG_EN
        // DRAM never completes: watchdog fires after WDOG cycles of WAIT
        req_valid = 2'b01;
        tick();
        check("wd_read_en", read_en, 1);
        req_valid = '0;
        for (int k = 0; k < WDOG; k++) begin
            tick();
        end
        check("wd_not_yet", resp_valid, 0);
        check("wd_err_not_yet", wdog_err, 0);
        tick();
        check("wd_resp_valid", resp_valid, 2'b01);
        check("wd_resp_rdata", resp_rdata, 0);
        check("wd_err", wdog_err, 1);
        req_we = 2'b10;
        req_valid = 2'b10;
        tick();
        check("wd_next_write_en", write_en, 1);
        check("wd_next_req_ready", req_ready, 2'b10);
        req_valid = '0;
        tick();
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
        check("wd_next_resp", resp_valid, 2'b10);
        check("wd_err_sticky", wdog_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single DRAM port (addr/read_en/write_en/wdata ↔ dram_ready/dram_complete/rdata/valid) among N_REQ requesters, e.g. several PIM matmul engines, or a host loader plus an engine.
- Sits between the requesters and the dram instance, inside the top-level wrapper.
- Round-robin grant, one outstanding DRAM transaction at a time.
- The granted command is latched, issued for one cycle, and the grant is held until the DRAM signals completion.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, ADDRESS_LEN (types), DRAM address width.
- DATA_W, BURST_ACCESS_WIDTH (types), burst data width.
- WDOG_CYCLES, 1024, watchdog limit in cycles; used only with DRAM_ARB_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- req_valid  in  N_REQ  per-requester request pending
- req_we  in  N_REQ  per-requester 1 = write, 0 = read
- req_addr  in  N_REQ x ADDR_W  per-requester address
- req_wdata  in  N_REQ x DATA_W  per-requester write data
- req_ready  out  N_REQ  one-hot one-cycle pulse: request accepted (latched)
- resp_valid  out  N_REQ  one-hot one-cycle pulse: transaction finished
- resp_rdata  out  DATA_W  read data, valid when resp_valid is set for a read
- addr  out  ADDR_W  to DRAM
- read_en  out  1  to DRAM
- write_en  out  1  to DRAM
- wdata  out  DATA_W  to DRAM
- dram_ready  in  1  DRAM idle / able to accept
- dram_complete  in  1  DRAM write done (pulse)
- rdata  in  DATA_W  DRAM read data
- valid  in  1  DRAM read data valid (pulse)
- wdog_err  out  1  sticky timeout flag; exists only with DRAM_ARB_WATCHDOG_EN

Behaviour:
- Reset values (rst=0, asynchronous): state IDLE; outputs req_ready, resp_valid, resp_rdata, addr, read_en, write_en, wdata, wdog_err all 0; rr pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid and dram_ready=1, pick winner g as the first set req_valid scanning from (ptr+1) mod N_REQ upward with wrap.
  - Latch addr/wdata/we of g into the output registers, set ptr = g, go to ISSUE.
  - With no request, or dram_ready=0: stay in IDLE and grant nothing.
- ISSUE (exactly one cycle):
  - read_en = ~we or write_en = we, never both.
  - req_ready[g] = 1.
  - Go to WAIT.
- WAIT:
  - For a read, wait for valid=1: capture rdata into resp_rdata, pulse resp_valid[g] on the next cycle, go to IDLE.
  - For a write, wait for dram_complete=1: pulse resp_valid[g] on the next cycle, go to IDLE. resp_rdata is unchanged.
- Latency: request at cycle N (IDLE, dram_ready=1) → read_en/write_en and req_ready at N+1. DRAM completion at cycle M → resp_valid at M+1. The earliest next grant decision is at M+1.
- addr/wdata are held stable from ISSUE until the end of WAIT. A requester may change or drop its inputs after its req_ready pulse.
- A requester dropping req_valid before it is granted is legal; no grant is issued to it.
- Fairness: a continuously requesting requester is granted within N_REQ grants.
- Ignored events:
  - valid and dram_complete in IDLE or ISSUE.
  - dram_complete during a read WAIT.
  - valid during a write WAIT.
- Reset mid-operation: abandon the in-flight transaction; no resp_valid is produced for it. Completions arriving after reset are ignored per the rule above.

Optional Feature:
- Macro DRAM_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - When it reaches WDOG_CYCLES without completion: set wdog_err (sticky until reset), pulse resp_valid[g] with resp_rdata = 0, return to IDLE.
- Undefined: the wdog_err port and the counter do not exist, and WAIT waits indefinitely.

Decomposition:
- Package types:
  - Add typedef enum dram_arb_state_t {IDLE, ISSUE, WAIT}.
  - Add constant DRAM_ARB_N_REQ = 2.
  - Reuse ADDRESS_LEN and BURST_ACCESS_WIDTH.
- Sub-module rr_arbiter: combinational N_REQ round-robin picker. Inputs are the req vector and ptr; outputs are the one-hot grant and its index. dram_port_arbiter instantiates it once and owns ptr.

Test Plan:
- Reset, then req_valid=01, we=0, addr=0x40, dram_ready=1 → read_en=1 and addr=0x40 one cycle later. DRAM returns valid with rdata=0xA5 → resp_valid=01 and resp_rdata=0xA5 the next cycle.
- Both requesters request continuously with writes, DRAM completes 3 cycles after issue → grant order 0,1,0,1. Each req_ready is one-hot with no gaps beyond protocol latency.
- dram_ready=0 for 5 cycles with req_valid=10 → no read_en/write_en and no req_ready. dram_ready goes to 1 → issue for requester 1 at the next cycle.
- Requester 1 write in WAIT, spurious valid=1 injected → ignored. Then dram_complete → resp_valid=10, resp_rdata unchanged.
- rst driven to 0 during a read WAIT, then released; DRAM then pulses valid → no resp_valid, state IDLE. The first subsequent request is granted to requester 0.
- With DRAM_ARB_WATCHDOG_EN and WDOG_CYCLES=16, DRAM never completes → after 16 WAIT cycles wdog_err=1 and resp_valid is pulsed for the granted requester with resp_rdata=0. The next request is still serviced.
